// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates the pipe and fetch enables,
// drains in-flight instructions after a halt opcode, and counts active cycles.
module pipeline_run_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt,
  input  logic             i_halt_instr_id,
  input  logic             i_stall,
  input  logic             i_clear_cnt,
  output logic             o_pipe_en,
  output logic             o_fetch_en,
  output logic             o_running,
  output logic             o_halted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               fgo;

  // State and drain counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state and enable decode
  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    o_pipe_en  = 1'b0;
    o_fetch_en = 1'b0;
    fgo        = ~i_stall & ~i_halt_instr_id;
    case (state)
      IDLE: begin
        if (i_halt)      state_nxt = IDLE;
        else if (i_run)  state_nxt = RUN;
        else if (i_step) state_nxt = STEP;
      end
      RUN: begin
        o_pipe_en  = 1'b1;
        o_fetch_en = fgo;
        if (i_halt) begin
          state_nxt = IDLE;
        end else if (i_halt_instr_id && !i_stall) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_W'(DRAIN_CYCLES - 1);
        end
      end
      STEP: begin
        o_pipe_en  = 1'b1;
        o_fetch_en = fgo;
        if (i_halt_instr_id && !i_stall) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_W'(DRAIN_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        o_pipe_en = 1'b1;
        if (drain_cnt == '0) state_nxt = DONE;
        else                 drain_nxt = drain_cnt - DRAIN_W'(1);
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating active-cycle counter; clear beats increment
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cycle_cnt <= '0;
    end else if (i_clear_cnt) begin
      o_cycle_cnt <= '0;
    end else if (o_pipe_en && (o_cycle_cnt != '1)) begin
      o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
    end
  end

  assign o_running = (state == RUN) || (state == DRAIN);
  assign o_halted  = (state == DONE);
  assign o_state   = 3'(state);

endmodule
